// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
//  - Default 640x480@60 timing constants (pixels / lines).
//  - Derived totals H_TOTAL / V_TOTAL (both must stay <= 1024 to fit vga_coord_t).
//  - vga_coord_t: 10-bit raster coordinate, vga_color_t: 8-bit colour channel.
//  - axis_total(): sums the four segments of one raster axis.
package vga_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] vga_coord_t;
  typedef logic [7:0]         vga_color_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing generator and the colour mapping / DAC side.
//  master modport (timing generator): drives coordinates, sync, blank, colour
//                                     to DAC; receives pix_r/g/b.
//  slave modport  (colour mapping)  : supplies pix_r/g/b for DrawX/DrawY and
//                                     observes everything else.
interface vga_timing_gen_if;
  import vga_pkg::*;

  vga_color_t pix_r;
  vga_color_t pix_g;
  vga_color_t pix_b;
  vga_coord_t DrawX;
  vga_coord_t DrawY;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  vga_color_t VGA_R;
  vga_color_t VGA_G;
  vga_color_t VGA_B;

  modport master (
    input  pix_r, pix_g, pix_b,
    output DrawX, DrawY, frame_start, VGA_CLK, VGA_HS, VGA_VS,
           VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  DrawX, DrawY, frame_start, VGA_CLK, VGA_HS, VGA_VS,
           VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical) counter.
//  clk_i    : clock
//  rst_i    : synchronous active-high reset
//  inc_i    : advance the count by one this cycle
//  count_o  : current position 0..TOTAL-1
//  wrap_o   : inc_i while at TOTAL-1 (the count returns to 0 on this edge)
//  sync_n_o : registered, low while count is inside the sync segment
//  active_o : registered, high while count is inside the visible segment
// sync_n/active are computed from the next count so they line up with count_o.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output vga_coord_t count_o,
  output logic       wrap_o,
  output logic       sync_n_o,
  output logic       active_o
);

  localparam int         TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam vga_coord_t LAST       = vga_coord_t'(TOTAL - 1);
  localparam vga_coord_t SYNC_START = vga_coord_t'(VISIBLE + FRONT);
  localparam vga_coord_t SYNC_END   = vga_coord_t'(VISIBLE + FRONT + SYNC);
  localparam vga_coord_t VIS_END    = vga_coord_t'(VISIBLE);
  localparam vga_coord_t COUNT_ZERO = vga_coord_t'(0);
  localparam vga_coord_t COUNT_ONE  = vga_coord_t'(1);

  vga_coord_t count_q;
  vga_coord_t count_d;
  logic       sync_n_q;
  logic       sync_n_d;
  logic       active_q;
  logic       active_d;
  logic       last_s;

  assign last_s = (count_q == LAST);
  assign wrap_o = inc_i && last_s;

  // Next count and the decoded sync/visible flags for that next count.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if (last_s) begin
        count_d = COUNT_ZERO;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
    sync_n_d = !((count_d >= SYNC_START) && (count_d < SYNC_END));
    active_d = (count_d < VIS_END);
  end

  // Count and decoded flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= COUNT_ZERO;
      sync_n_q <= 1'b1;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign count_o  = count_q;
  assign sync_n_o = sync_n_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
//  Clk    : system clock, single domain
//  Reset  : synchronous active-high reset
//  vga    : vga_timing_gen_if.master - pix_r/g/b in; DrawX/DrawY,
//           frame_start, VGA_CLK/HS/VS/BLANK_N/SYNC_N and VGA_R/G/B out.
// A Clk divider produces the pixel enable pe; a horizontal axis counter
// advances on pe and a vertical one on pe at the end of each line.
// Optional macro VGA_RGB_REG_EN: colour is registered on pe and HS/VS/BLANK_N
// are delayed by one pixel to match; DrawX/DrawY then lead the DAC by one
// pixel. Default (macro undefined): colour is passed through combinationally,
// gated by blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input logic              Clk,
  input logic              Reset,
  vga_timing_gen_if.master vga
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             pe_s;
  logic             vga_clk_q;
  logic             frame_start_q;

  vga_coord_t h_count_s;
  vga_coord_t v_count_s;
  logic       h_wrap_s;
  logic       v_wrap_s;
  logic       h_sync_n_s;
  logic       v_sync_n_s;
  logic       h_active_s;
  logic       v_active_s;
  logic       v_inc_s;
  logic       blank_n_s;

  assign pe_s    = (div_q == DIV_LAST);
  assign v_inc_s = pe_s && h_wrap_s;

  // Divider next state: free-running 0..CLK_DIV-1.
  always_comb begin
    if (pe_s) begin
      div_d = DIV_ZERO;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Divider, pixel clock and frame-start registers. VGA_CLK is taken from
  // the next divider value so it is high exactly for the upper half of the count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= DIV_ZERO;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      vga_clk_q     <= (div_d >= DIV_HALF);
      frame_start_q <= h_wrap_s && v_wrap_s;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .inc_i    (pe_s),
    .count_o  (h_count_s),
    .wrap_o   (h_wrap_s),
    .sync_n_o (h_sync_n_s),
    .active_o (h_active_s)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .inc_i    (v_inc_s),
    .count_o  (v_count_s),
    .wrap_o   (v_wrap_s),
    .sync_n_o (v_sync_n_s),
    .active_o (v_active_s)
  );

  // Both active flags are registered, so this AND is aligned with DrawX/DrawY.
  assign blank_n_s = h_active_s && v_active_s;

  assign vga.DrawX       = h_count_s;
  assign vga.DrawY       = v_count_s;
  assign vga.frame_start = frame_start_q;
  assign vga.VGA_CLK     = vga_clk_q;
  assign vga.VGA_SYNC_N  = 1'b0;

`ifdef VGA_RGB_REG_EN
  logic       hs_q;
  logic       vs_q;
  logic       blank_n_q;
  vga_color_t r_q;
  vga_color_t g_q;
  vga_color_t b_q;

  // One-pixel DAC stage: colour for the pixel just finished plus its timing flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
    end else if (pe_s) begin
      hs_q      <= h_sync_n_s;
      vs_q      <= v_sync_n_s;
      blank_n_q <= blank_n_s;
      r_q       <= blank_n_s ? vga.pix_r : 8'h00;
      g_q       <= blank_n_s ? vga.pix_g : 8'h00;
      b_q       <= blank_n_s ? vga.pix_b : 8'h00;
    end else begin
      hs_q      <= hs_q;
      vs_q      <= vs_q;
      blank_n_q <= blank_n_q;
      r_q       <= r_q;
      g_q       <= g_q;
      b_q       <= b_q;
    end
  end

  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
`else
  vga_color_t r_s;
  vga_color_t g_s;
  vga_color_t b_s;

  // Pass-through colour, forced to black outside the visible region.
  always_comb begin
    if (blank_n_s) begin
      r_s = vga.pix_r;
      g_s = vga.pix_g;
      b_s = vga.pix_b;
    end else begin
      r_s = 8'h00;
      g_s = 8'h00;
      b_s = 8'h00;
    end
  end

  assign vga.VGA_HS      = h_sync_n_s;
  assign vga.VGA_VS      = v_sync_n_s;
  assign vga.VGA_BLANK_N = blank_n_s;
  assign vga.VGA_R       = r_s;
  assign vga.VGA_G       = g_s;
  assign vga.VGA_B       = b_s;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen (default build, VGA_RGB_REG_EN undefined).
// Two instances share Clk/Reset: a reduced-timing one that reaches several
// frames quickly, and one with the default 640x480 timing for the first lines.
// Expected values come from the raster rules evaluated on the number of Clk
// edges seen since the last reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_DIV = 4;
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_FRAME = S_DIV * (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

  typedef struct packed {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic blank;
    logic vclk;
    logic fs;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] pr, pg, pb;
  int         t;
  int         vectors;
  int         miscompares;
  int         fs_count;

  vga_timing_gen_if vif_s();
  vga_timing_gen_if vif_d();

  assign vif_s.pix_r = pr;
  assign vif_s.pix_g = pg;
  assign vif_s.pix_b = pb;
  assign vif_d.pix_r = pr;
  assign vif_d.pix_g = pg;
  assign vif_d.pix_b = pb;

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .CLK_DIV   (S_DIV)
  ) u_small (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif_s)
  );

  vga_timing_gen u_default (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif_d)
  );

  always #5 Clk = ~Clk;

  // Raster rules: pixel index = edges / divider, then split into x / y.
  function automatic exp_t model(input int tt, input int d,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb);
    exp_t e;
    int ht, vt, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = tt / d;
    e.x     = p % ht;
    e.y     = (p / ht) % vt;
    e.hs    = !(e.x >= hv + hf && e.x < hv + hf + hsw);
    e.vs    = !(e.y >= vv + vf && e.y < vv + vf + vsw);
    e.blank = (tt != 0) && (e.x < hv) && (e.y < vv);
    e.vclk  = (tt % d) >= (d / 2);
    e.fs    = (tt != 0) && ((tt % (d * ht * vt)) == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, expv);
    end
  endtask

  task automatic check_small();
    exp_t e;
    e = model(t, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
    chk("s_drawx",   32'(vif_s.DrawX),       e.x);
    chk("s_drawy",   32'(vif_s.DrawY),       e.y);
    chk("s_hs",      32'(vif_s.VGA_HS),      32'(e.hs));
    chk("s_vs",      32'(vif_s.VGA_VS),      32'(e.vs));
    chk("s_blank_n", 32'(vif_s.VGA_BLANK_N), 32'(e.blank));
    chk("s_vga_clk", 32'(vif_s.VGA_CLK),     32'(e.vclk));
    chk("s_fstart",  32'(vif_s.frame_start), 32'(e.fs));
    chk("s_sync_n",  32'(vif_s.VGA_SYNC_N),  32'd0);
    chk("s_r",       32'(vif_s.VGA_R),       e.blank ? 32'(pr) : 32'd0);
    chk("s_g",       32'(vif_s.VGA_G),       e.blank ? 32'(pg) : 32'd0);
    chk("s_b",       32'(vif_s.VGA_B),       e.blank ? 32'(pb) : 32'd0);
    if (vif_s.frame_start === 1'b1) begin
      fs_count++;
    end else begin
      fs_count = fs_count;
    end
  endtask

  task automatic check_default();
    exp_t e;
    e = model(t, CLK_DIV_DEF, H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF,
              V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
    chk("d_drawx",   32'(vif_d.DrawX),       e.x);
    chk("d_drawy",   32'(vif_d.DrawY),       e.y);
    chk("d_hs",      32'(vif_d.VGA_HS),      32'(e.hs));
    chk("d_vs",      32'(vif_d.VGA_VS),      32'(e.vs));
    chk("d_blank_n", 32'(vif_d.VGA_BLANK_N), 32'(e.blank));
    chk("d_vga_clk", 32'(vif_d.VGA_CLK),     32'(e.vclk));
    chk("d_fstart",  32'(vif_d.frame_start), 32'(e.fs));
    chk("d_r",       32'(vif_d.VGA_R),       e.blank ? 32'(pr) : 32'd0);
  endtask

  // One Clk: update the edge count, sample away from the edge, then new colour.
  task automatic tick(input bit rand_pix);
    @(posedge Clk);
    if (Reset) t = 0;
    else       t = t + 1;
    #1;
    check_small();
    check_default();
    if (rand_pix) begin
      pr = 8'($urandom);
      pg = 8'($urandom);
      pb = 8'($urandom);
    end
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    fs_count    = 0;
    t           = 0;
    pr = 8'hFF;
    pg = 8'hFF;
    pb = 8'hFF;

    // Reset state held for a few cycles.
    Reset = 1'b1;
    repeat (3) tick(1'b0);
    Reset = 1'b0;

    // Full white: blanking regions must read 0, visible ones FF.
    repeat (S_FRAME + 100) tick(1'b0);

    // Random colour across further frames and the default line wrap (1600 Clk).
    repeat (1100) tick(1'b1);
    chk("s_fs_count", 32'(fs_count), 32'(t / S_FRAME));

    // Mid-frame resets at random points.
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(800, 50));
      repeat (n) tick(1'b1);
      Reset = 1'b1;
      repeat (int'($urandom_range(3, 1))) tick(1'b1);
      Reset = 1'b0;
    end

    // Free run after the last reset: first frame_start after a full frame.
    fs_count = 0;
    repeat (S_FRAME * 2 + 50) tick(1'b1);
    chk("s_fs_after_rst", 32'(fs_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
